// File: rtl/move_pkg.sv
// -----------------------------------------------------------------------------
// move_pkg
//   Shared types for the move scheduler: decoded direction encoding, the WASD
//   keycodes, the keycode-to-direction decoder and the scheduler FSM states.
// -----------------------------------------------------------------------------
package move_pkg;

   typedef enum logic [2:0] {
      DIR_NONE  = 3'd0,
      DIR_UP    = 3'd1,
      DIR_DOWN  = 3'd2,
      DIR_LEFT  = 3'd3,
      DIR_RIGHT = 3'd4
   } dir_t;

   localparam logic [7:0] KEY_W = 8'h1A;
   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_D = 8'h07;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } sched_state_t;

   // Non-direction keycodes map to DIR_NONE so the caller can drop them.
   function automatic dir_t decode_key(input logic [7:0] key);
      case (key)
         KEY_W:   return DIR_UP;
         KEY_S:   return DIR_DOWN;
         KEY_A:   return DIR_LEFT;
         KEY_D:   return DIR_RIGHT;
         default: return DIR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// -----------------------------------------------------------------------------
// move_scheduler_if
//   Requester and command handshakes of the move scheduler.
//   req_valid/req_key : keycode requesters (key i in bits [8i+7:8i])
//   req_ack           : one-hot grant back to the requesters
//   cmd_valid/cmd_dir : pending direction command toward the ball logic
//   cmd_ready         : consumer accepts the command
//   master : requester/consumer side      slave : scheduler side
// -----------------------------------------------------------------------------
interface move_scheduler_if
   import move_pkg::*;
#(
   parameter int NUM_REQ = 2
);

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*8-1:0] req_key;
   logic [NUM_REQ-1:0]   req_ack;
   logic                 cmd_valid;
   dir_t                 cmd_dir;
   logic                 cmd_ready;

   modport master (
      output req_valid, req_key, cmd_ready,
      input  req_ack, cmd_valid, cmd_dir
   );

   modport slave (
      input  req_valid, req_key, cmd_ready,
      output req_ack, cmd_valid, cmd_dir
   );

endinterface

// File: rtl/dir_fifo.sv
// -----------------------------------------------------------------------------
// dir_fifo
//   Synchronous FIFO of decoded directions.
//   clk, rst_n          : clock, asynchronous active-low clear
//   push_i, push_data_i : enqueue request and data (ignored when full)
//   pop_i               : dequeue request (ignored when empty)
//   full_o, empty_o     : occupancy flags
//   count_o             : current occupancy
//   head_o              : oldest entry
//   last_o              : most recently pushed entry
// -----------------------------------------------------------------------------
module dir_fifo
   import move_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push_i,
   input  dir_t                          push_data_i,
   input  logic                          pop_i,
   output logic                          full_o,
   output logic                          empty_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   output dir_t                          head_o,
   output dir_t                          last_o
);

   localparam int AW = $clog2(FIFO_DEPTH);

   dir_t              mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       count_q, count_d;
   dir_t              last_q;
   logic              push_ok, pop_ok;

   assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         last_q   <= DIR_NONE;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            last_q   <= push_data_i;
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // NOTE: storage is not reset; occupancy is tracked by the pointers and count alone.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign last_o  = last_q;

endmodule

// File: rtl/move_scheduler.sv
// -----------------------------------------------------------------------------
// move_scheduler
//   Round-robin merge of WASD keycode requesters into a direction FIFO, and
//   release of at most one command per frame tick to the ball logic.
//   Clk, Reset_n : system clock, asynchronous active-low reset
//   frame_clk    : frame strobe, asynchronous to Clk (rising edges used)
//   bus          : requester and command handshakes (slave side)
//   fifo_count   : current FIFO occupancy
//   overrun_cnt  : ticks that arrived while a command was unaccepted (sat. 255)
// -----------------------------------------------------------------------------
module move_scheduler
   import move_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        Clk,
   input  logic                        Reset_n,
   input  logic                        frame_clk,
   move_scheduler_if.slave             bus,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic [7:0]                  overrun_cnt
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [7:0]        keys [NUM_REQ];
   logic [PW-1:0]     ptr_q, ptr_d, gnt_idx, scan_idx;
   logic [NUM_REQ-1:0] grant;
   logic              gnt_found;
   dir_t              key_dir, fifo_head, fifo_last;
   logic              fifo_full, fifo_empty, push, pop;
   logic              sync1_q, sync2_q, edge_q, tick;
   sched_state_t      state_q, state_d;
   dir_t              cmd_dir_q, cmd_dir_d;
   logic [7:0]        overrun_q, overrun_d;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_keys
      assign keys[g] = bus.req_key[8*g +: 8];
   end

   // Scan requesters starting at the pointer; the first valid one wins.
   always_comb begin
      grant     = '0;
      gnt_idx   = '0;
      gnt_found = 1'b0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = PW'((int'(ptr_q) + k) % NUM_REQ);
         if (!gnt_found && bus.req_valid[scan_idx] && !fifo_full && Reset_n) begin
            grant[scan_idx] = 1'b1;
            gnt_idx         = scan_idx;
            gnt_found       = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_found) ptr_d = (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
   end

   assign bus.req_ack = grant;
   assign key_dir     = decode_key(keys[gnt_idx]);
   // Unknown codes and repeats of the newest queued entry are acked but dropped.
   assign push = gnt_found && (key_dir != DIR_NONE) &&
                 !(!fifo_empty && (key_dir == fifo_last));

   dir_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (Clk),
      .rst_n       (Reset_n),
      .push_i      (push),
      .push_data_i (key_dir),
      .pop_i       (pop),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count),
      .head_o      (fifo_head),
      .last_o      (fifo_last)
   );

   // The chain resets to "high" so a frame_clk already high at reset release
   // is not mistaken for a rising edge; only a later low-to-high makes a tick.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         edge_q  <= 1'b1;
      end else begin
         sync1_q <= frame_clk;
         sync2_q <= sync1_q;
         edge_q  <= sync2_q;
      end
   end

   assign tick = sync2_q && !edge_q;

   always_comb begin
      state_d   = state_q;
      cmd_dir_d = cmd_dir_q;
      overrun_d = overrun_q;
      pop       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tick && !fifo_empty) begin
               pop       = 1'b1;
               cmd_dir_d = fifo_head;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Acceptance wins over a coincident tick: not an overrun, no pop.
            if (bus.cmd_ready) state_d = ST_IDLE;
            else if (tick && overrun_q != 8'hFF) overrun_d = overrun_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= ST_IDLE;
         cmd_dir_q <= DIR_NONE;
         overrun_q <= '0;
         ptr_q     <= '0;
      end else begin
         state_q   <= state_d;
         cmd_dir_q <= cmd_dir_d;
         overrun_q <= overrun_d;
         ptr_q     <= ptr_d;
      end
   end

   assign bus.cmd_valid = (state_q == ST_ISSUE);
   assign bus.cmd_dir   = cmd_dir_q;
   assign overrun_cnt   = overrun_q;

endmodule

// File: tb/tb_move_scheduler.sv
// -----------------------------------------------------------------------------
// tb_move_scheduler
//   Directed scenarios plus a randomized phase, every cycle compared against a
//   queue-based reference model of the scheduler.
// -----------------------------------------------------------------------------
module tb_move_scheduler;
   import move_pkg::*;

   localparam int N     = 2;
   localparam int DEPTH = 4;

   logic       Clk;
   logic       Reset_n;
   logic       frame_clk;
   logic [2:0] fifo_count;
   logic [7:0] overrun_cnt;

   move_scheduler_if #(.NUM_REQ(N)) bus ();

   move_scheduler #(.NUM_REQ(N), .FIFO_DEPTH(DEPTH)) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .frame_clk   (frame_clk),
      .bus         (bus),
      .fifo_count  (fifo_count),
      .overrun_cnt (overrun_cnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   dir_t mq[$];
   int   m_ptr;
   bit   m_issue;
   dir_t m_dir;
   int   m_ovr;
   bit   h1, h2, h3;   // frame_clk as seen at the last three Clk edges
   int   last_grant;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic dir_t ref_decode(input logic [7:0] k);
      if (k == 8'h1A) return DIR_UP;
      if (k == 8'h16) return DIR_DOWN;
      if (k == 8'h04) return DIR_LEFT;
      if (k == 8'h07) return DIR_RIGHT;
      return DIR_NONE;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ptr   = 0;
      m_issue = 1'b0;
      m_dir   = DIR_NONE;
      m_ovr   = 0;
      h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
   endtask

   // Runs one Clk cycle: starts and ends 1 time unit after a rising edge.
   task automatic do_cycle();
      int         g;
      logic [1:0] exp_ack;
      dir_t       d;
      bit         do_push, tick;
      @(negedge Clk);
      g = -1;
      if (Reset_n && mq.size() < DEPTH)
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && 1'((bus.req_valid >> idx)) == 1'b1) g = idx;
         end
      exp_ack = (g >= 0) ? 2'(1 << g) : 2'b00;
      check("req_ack", 32'(bus.req_ack), 32'(exp_ack));
      last_grant = g;
      d = (g >= 0) ? ref_decode(8'(bus.req_key >> (8*g))) : DIR_NONE;
      do_push = (g >= 0) && (d != DIR_NONE) && !(mq.size() > 0 && d == mq[$]);
      @(posedge Clk);
      if (!Reset_n) model_reset();
      else begin
         tick = h2 && !h3;
         if (g >= 0) m_ptr = (g + 1) % N;
         if (!m_issue) begin
            if (tick && mq.size() > 0) begin
               m_dir   = mq.pop_front();
               m_issue = 1'b1;
            end
         end else if (bus.cmd_ready) m_issue = 1'b0;
         else if (tick && m_ovr < 255) m_ovr++;
         if (do_push) mq.push_back(d);
         h3 = h2; h2 = h1; h1 = frame_clk;
      end
      #1;
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("cmd_valid", 32'(bus.cmd_valid), 32'(m_issue));
      check("cmd_dir", 32'(bus.cmd_dir), 32'(m_dir));
      check("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
   endtask

   task automatic apply_reset(input int n);
      bus.req_valid = '0;
      bus.cmd_ready = 1'b0;
      frame_clk     = 1'b0;
      Reset_n       = 1'b0;
      model_reset();
      repeat (n) do_cycle();
      Reset_n = 1'b1;
   endtask

   task automatic frame_pulse();
      frame_clk = 1'b1;
      repeat (2) do_cycle();
      frame_clk = 1'b0;
      repeat (2) do_cycle();
   endtask

   // Pulse frame_clk and wait (bounded) for a command to appear.
   task automatic pulse_and_wait(input string tag);
      int n;
      frame_clk = 1'b1;
      repeat (2) do_cycle();
      frame_clk = 1'b0;
      n = 0;
      while (!bus.cmd_valid && n < 8) begin
         do_cycle();
         n++;
      end
      check(tag, 32'(bus.cmd_valid), 32'd1);
   endtask

   task automatic push_key(input logic [7:0] k);
      bus.req_valid = 2'b01;
      bus.req_key   = {8'h00, k};
      do_cycle();
      bus.req_valid = 2'b00;
   endtask

   initial begin
      logic [7:0] tbl [6];
      tbl = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C, 8'h00};
      bus.req_key = '0;

      // Reset values
      apply_reset(3);
      check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
      check("rst_cmd_dir", 32'(bus.cmd_dir), 32'd0);
      check("rst_overrun", 32'(overrun_cnt), 32'd0);
      repeat (5) do_cycle();
      check("rst_idle_valid", 32'(bus.cmd_valid), 32'd0);

      // Round-robin with both requesters always valid
      bus.req_key   = {8'h07, 8'h1A};
      bus.req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         do_cycle();
         check("rr_grant", 32'(last_grant), 32'(i % 2));
      end
      check("rr_full_count", 32'(fifo_count), 32'd4);
      check("rr_full_ack", 32'(bus.req_ack), 32'd0);
      do_cycle();
      bus.req_valid = 2'b00;

      // Frame issue: UP then LEFT, one per frame
      apply_reset(2);
      push_key(8'h1A);
      push_key(8'h04);
      check("fi_count2", 32'(fifo_count), 32'd2);
      bus.cmd_ready = 1'b1;
      pulse_and_wait("fi_tick1_timeout");
      check("fi_dir1", 32'(bus.cmd_dir), 32'(DIR_UP));
      check("fi_count1", 32'(fifo_count), 32'd1);
      do_cycle();
      check("fi_valid_drop", 32'(bus.cmd_valid), 32'd0);
      pulse_and_wait("fi_tick2_timeout");
      check("fi_dir2", 32'(bus.cmd_dir), 32'(DIR_LEFT));
      check("fi_count0", 32'(fifo_count), 32'd0);
      do_cycle();
      bus.cmd_ready = 1'b0;

      // Decode drop and duplicate suppression
      apply_reset(2);
      bus.req_valid = 2'b01;
      foreach (tbl[i]) begin
         if (i >= 3) break;
         bus.req_key = {8'h00, (i == 0) ? 8'h2C : 8'h16};
         #1;
         check("dd_ack", 32'(bus.req_ack), 32'd1);
         do_cycle();
      end
      bus.req_valid = 2'b00;
      check("dd_count", 32'(fifo_count), 32'd1);

      // Overrun: DOWN issued, consumer stalls across three ticks
      push_key(8'h04);
      bus.cmd_ready = 1'b0;
      frame_pulse();
      check("ov_issue_dir", 32'(bus.cmd_dir), 32'(DIR_DOWN));
      repeat (3) frame_pulse();
      check("ov_count3", 32'(overrun_cnt), 32'd3);
      check("ov_dir_stable", 32'(bus.cmd_dir), 32'(DIR_DOWN));
      check("ov_valid_held", 32'(bus.cmd_valid), 32'd1);
      // Tie: cmd_ready raised exactly in the tick cycle
      frame_clk = 1'b1;
      repeat (2) do_cycle();
      bus.cmd_ready = 1'b1;
      do_cycle();
      bus.cmd_ready = 1'b0;
      frame_clk     = 1'b0;
      check("tie_valid_fall", 32'(bus.cmd_valid), 32'd0);
      check("tie_no_incr", 32'(overrun_cnt), 32'd3);
      check("tie_no_pop", 32'(fifo_count), 32'd1);
      repeat (3) do_cycle();

      // Reset in the middle of a handshake
      apply_reset(2);
      bus.req_key   = {8'h07, 8'h1A};
      bus.req_valid = 2'b11;
      repeat (4) do_cycle();
      bus.req_valid = 2'b00;
      frame_pulse();
      check("mr_count3", 32'(fifo_count), 32'd3);
      check("mr_issue", 32'(bus.cmd_valid), 32'd1);
      frame_clk     = 1'b1;
      bus.req_valid = 2'b11;
      #2;
      Reset_n = 1'b0;
      #1;
      check("mr_async_valid", 32'(bus.cmd_valid), 32'd0);
      check("mr_async_count", 32'(fifo_count), 32'd0);
      check("mr_async_ack", 32'(bus.req_ack), 32'd0);
      model_reset();
      @(posedge Clk);
      #1;
      repeat (2) do_cycle();
      Reset_n       = 1'b1;
      bus.req_valid = 2'b01;
      repeat (6) do_cycle();
      check("mr_no_tick", 32'(bus.cmd_valid), 32'd0);
      bus.req_valid = 2'b00;
      frame_clk     = 1'b0;

      // Randomized traffic against the model
      apply_reset(2);
      for (int c = 0; c < 600; c++) begin
         bus.req_valid = 2'($urandom);
         bus.req_key   = {tbl[$urandom_range(5)], tbl[$urandom_range(5)]};
         if (($urandom % 7) == 0) bus.req_key[7:0] = 8'($urandom);
         bus.cmd_ready = (($urandom % 4) == 0);
         if (($urandom % 5) == 0) frame_clk = ~frame_clk;
         do_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
